// File: rtl/buffer_16.sv
// Word buffer: `in` passes straight to `out` (0 cycles); `out_q` is `in` registered on rising clk (1 cycle).
// `delta` is the combinational in ^ out_q change mask. There is no handshake and no backpressure.
module buffer_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] delta
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Pure wire path: must stay valid even when clk/reset are left floating.
    assign out    = in;

    assign data_d = in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_q = data_q;
    assign delta = in ^ data_q;

endmodule

// File: tb/tb_buffer_16.sv
// Self-checking bench for buffer_16: random pass-through, corner words, reset and register behaviour.
module tb_buffer_16;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] dout_q;
    logic [15:0] delta;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the last word captured by the register (0 after reset).
    logic [15:0] model_q;

    buffer_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .out   (dout),
        .out_q (dout_q),
        .delta (delta)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full clock period; optionally releases reset in the same instant as the rising edge.
    task automatic tick(input bit release_rst);
        if (release_rst) reset = 1'b0;
        clk = 1'b1;
        if (!reset) model_q = din;
        #1;
        chk("out_q_edge", dout_q, model_q);
        chk("delta_edge", delta, din ^ model_q);
        chk("out_edge", dout, din);
        #4 clk = 1'b0;
        #5;
    endtask

    logic [15:0] corners [5];
    int          r;

    initial begin
        corners = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h8001};
        model_q = '0;

        // Pass-through with clk and reset never driven.
        for (int i = 0; i < 10000; i++) begin
            din = 16'($urandom);
            #1;
            chk("passthru", dout, din);
        end
        for (int i = 0; i < 5; i++) begin
            din = corners[i];
            #1;
            chk("corner", dout, corners[i]);
        end

        // Reset independence.
        clk   = 1'b0;
        reset = 1'b1;
        din   = 16'h1234;
        #1;
        chk("rst_out", dout, 16'h1234);
        chk("rst_out_q", dout_q, 16'h0000);
        chk("rst_delta", delta, 16'h1234);

        // Register latency.
        reset = 1'b0;
        din   = 16'hBEEF;
        #4;
        tick(1'b0);
        chk("lat_out_q", dout_q, 16'hBEEF);
        chk("lat_delta", delta, 16'h0000);
        din = 16'hBEEE;
        #1;
        chk("lat_delta_1", delta, 16'h0001);
        chk("lat_out", dout, 16'hBEEE);

        // Async reset between edges.
        din = 16'hBEEF;
        #1;
        reset = 1'b1;
        model_q = '0;
        #1;
        chk("arst_out_q", dout_q, 16'h0000);
        chk("arst_out", dout, 16'hBEEF);
        din = 16'h5A5A;
        #1;
        chk("arst_track", dout, 16'h5A5A);
        chk("arst_hold", dout_q, 16'h0000);

        // Reset released exactly at a rising edge: that edge must load.
        din = 16'hC0DE;
        #2;
        tick(1'b1);
        chk("rel_edge_load", dout_q, 16'hC0DE);

        // Randomized registered operation with occasional async resets.
        for (int i = 0; i < 400; i++) begin
            din = 16'($urandom);
            #1;
            chk("rnd_out", dout, din);
            chk("rnd_delta", delta, din ^ model_q);
            r = $urandom_range(0, 7);
            if (r <= 1) begin
                reset   = 1'b1;
                model_q = '0;
                #1;
                chk("rnd_arst", dout_q, 16'h0000);
                chk("rnd_arst_delta", delta, din);
                if (r == 0) begin
                    reset = 1'b0;
                    #1;
                    tick(1'b0);
                end else begin
                    #1;
                    tick(1'b1);
                end
            end else begin
                #2;
                tick(1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
